// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing: pixel divider, h/v counters, syncs, frame and game ticks
module vga_timing_gen #(
    parameter int CLK_DIV         = 4,
    parameter int H_TOTAL         = 800,
    parameter int H_SYNC          = 96,
    parameter int H_VIS_START     = 144,
    parameter int H_VIS_END       = 784,
    parameter int V_TOTAL         = 525,
    parameter int V_SYNC          = 2,
    parameter int V_VIS_START     = 35,
    parameter int V_VIS_END       = 515,
    parameter int FRAMES_PER_TICK = 2
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       bright,
    output logic       hSync,
    output logic       vSync,
    output logic       pix_tick,
    output logic       frame_tick,
    output logic       game_tick
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FW = (FRAMES_PER_TICK > 1) ? $clog2(FRAMES_PER_TICK) : 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [FW-1:0] FCNT_LAST = FW'(FRAMES_PER_TICK - 1);
    localparam logic [9:0]    H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]    H_SYNC_W  = 10'(H_SYNC);
    localparam logic [9:0]    V_SYNC_W  = 10'(V_SYNC);
    localparam logic [9:0]    H_VS      = 10'(H_VIS_START);
    localparam logic [9:0]    H_VE      = 10'(H_VIS_END);
    localparam logic [9:0]    V_VS      = 10'(V_VIS_START);
    localparam logic [9:0]    V_VE      = 10'(V_VIS_END);

    logic [DW-1:0] div;
    logic [FW-1:0] fcnt;
    logic [9:0]    h_next;
    logic [9:0]    v_next;
    logic          frame_wrap;

    assign pix_tick = (div == DIV_LAST);

    // Pixel-enable divider: free-running 0..CLK_DIV-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= '0;
        end else if (pix_tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Next raster position; line and frame wrap resolved in the same step
    always_comb begin
        h_next     = hCount;
        v_next     = vCount;
        frame_wrap = 1'b0;
        if (pix_tick) begin
            if (hCount == H_LAST) begin
                h_next = '0;
                if (vCount == V_LAST) begin
                    v_next     = '0;
                    frame_wrap = 1'b1;
                end else begin
                    v_next = vCount + 10'd1;
                end
            end else begin
                h_next = hCount + 10'd1;
            end
        end
    end

    // Counters plus sync/bright decoded from the next position so they track the counters exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hCount <= '0;
            vCount <= '0;
            hSync  <= 1'b0;
            vSync  <= 1'b0;
            bright <= 1'b0;
        end else begin
            hCount <= h_next;
            vCount <= v_next;
            hSync  <= (h_next >= H_SYNC_W);
            vSync  <= (v_next >= V_SYNC_W);
            bright <= (h_next >= H_VS) && (h_next < H_VE) &&
                      (v_next >= V_VS) && (v_next < V_VE);
        end
    end

    // Frame counter and one-cycle frame/game pulses following a frame wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt       <= '0;
            frame_tick <= 1'b0;
            game_tick  <= 1'b0;
        end else begin
            frame_tick <= frame_wrap;
            game_tick  <= frame_wrap && (fcnt == FCNT_LAST);
            if (frame_wrap) begin
                fcnt <= (fcnt == FCNT_LAST) ? '0 : fcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen with a reduced raster
module tb_vga_timing_gen;

    localparam int CD  = 4;
    localparam int HT  = 20;
    localparam int HS  = 3;
    localparam int HVS = 5;
    localparam int HVE = 17;
    localparam int VT  = 10;
    localparam int VS  = 2;
    localparam int VVS = 3;
    localparam int VVE = 8;
    localparam int FPT = 2;
    localparam int FRAME = HT * VT * CD;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       bright;
    logic       hSync;
    logic       vSync;
    logic       pix_tick;
    logic       frame_tick;
    logic       game_tick;

    int     checks   = 0;
    int     failures = 0;
    longint k        = 0;
    bit     run      = 1'b0;

    vga_timing_gen #(
        .CLK_DIV(CD), .H_TOTAL(HT), .H_SYNC(HS), .H_VIS_START(HVS), .H_VIS_END(HVE),
        .V_TOTAL(VT), .V_SYNC(VS), .V_VIS_START(VVS), .V_VIS_END(VVE), .FRAMES_PER_TICK(FPT)
    ) dut (
        .clk(clk), .rst(rst), .hCount(hCount), .vCount(vCount), .bright(bright),
        .hSync(hSync), .vSync(vSync), .pix_tick(pix_tick), .frame_tick(frame_tick),
        .game_tick(game_tick)
    );

    always #5 clk = ~clk;

    // clock edges elapsed since reset was last released
    always @(posedge clk or posedge rst) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    function automatic logic [25:0] model(input longint e);
        longint p, h, v, fr;
        logic b, hs, vs, pt, ft, gt;
        p  = e / CD;
        h  = p % HT;
        v  = (p / HT) % VT;
        fr = p / (HT * VT);
        b  = (h >= HVS) && (h < HVE) && (v >= VVS) && (v < VVE);
        hs = !(h < HS);
        vs = !(v < VS);
        pt = (e % CD) == CD - 1;
        ft = (e > 0) && (e % CD == 0) && (p % (HT * VT) == 0);
        gt = ft && (fr % FPT == 0);
        return {10'(h), 10'(v), b, hs, vs, pt, ft, gt};
    endfunction

    function automatic logic [25:0] outs();
        return {hCount, vCount, bright, hSync, vSync, pix_tick, frame_tick, game_tick};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // every-cycle comparison against the arithmetic raster model
    always @(negedge clk) begin
        if (run) check("cycle", 64'(outs()), 64'(model(k)));
    end

    initial begin
        int n, nb, nv, nft, mask, wraps, misalign;
        bit found;

        #2 rst = 1'b1;
        run = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (37) @(posedge clk);

        // reset mid-line: outputs clear immediately and stay clear
        @(negedge clk) rst = 1'b1;
        #1 check("rst_async_zero", 64'(outs()), 64'd0);
        repeat (5) @(posedge clk);
        #1 check("rst_hold_zero", 64'(outs()), 64'd0);
        @(negedge clk) rst = 1'b0;

        step(); check("pix_edge1", 64'(pix_tick), 64'd0);
        step(); check("pix_edge2", 64'(pix_tick), 64'd0);
        step(); check("pix_edge3", 64'(pix_tick), 64'd1);
        check("h_edge3", 64'(hCount), 64'd0);
        step(); check("h_edge4", 64'(hCount), 64'd1);

        // horizontal wrap at (19,4)
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            if (hCount == 10'd19 && vCount == 10'd4 && pix_tick) found = 1'b1;
            else step();
        end
        check("hwrap_reached", 64'(found), 64'd1);
        step();
        check("hwrap_pos", 64'({hCount, vCount}), 64'({10'd0, 10'd5}));
        n = 0;
        while (hSync == 1'b0 && n < 1000) begin
            n++;
            step();
        end
        check("hsync_low_clks", 64'(n), 64'(HS * CD));

        // frame wrap at (19,9), then measure one full frame
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            if (hCount == 10'd19 && vCount == 10'd9 && pix_tick) found = 1'b1;
            else step();
        end
        check("fwrap_reached", 64'(found), 64'd1);
        step();
        check("fwrap_pos", 64'({hCount, vCount}), 64'd0);
        check("fwrap_frame_tick", 64'(frame_tick), 64'd1);
        nb = 0; nv = 0; nft = 0;
        for (int i = 0; i < FRAME; i++) begin
            nb  += int'(bright);
            nv  += int'(!vSync);
            nft += int'(frame_tick);
            step();
        end
        check("bright_clks", 64'(nb), 64'((HVE - HVS) * (VVE - VVS) * CD));
        check("vsync_low_clks", 64'(nv), 64'(VS * HT * CD));
        check("frame_tick_width", 64'(nft), 64'd1);
        check("frame_tick_period", 64'(frame_tick), 64'd1);

        // game_tick over five frames from a clean reset
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        mask = 0; wraps = 0; misalign = 0;
        for (int i = 0; i < 5 * FRAME + 8; i++) begin
            step();
            if (game_tick && !frame_tick) misalign++;
            if (frame_tick) begin
                wraps++;
                if (game_tick) mask |= 1 << (wraps - 1);
            end
        end
        check("game_wraps", 64'(wraps), 64'd5);
        check("game_mask", 64'(mask), 64'b01010);
        check("game_misalign", 64'(misalign), 64'd0);

        // async reset mid-frame with fcnt=1
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            if (vCount == 10'd6) found = 1'b1;
            else step();
        end
        check("mid_reached", 64'(found), 64'd1);
        #1 rst = 1'b1;
        #1 check("mid_rst_async_zero", 64'(outs()), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        n = 0; nft = 0; found = 1'b0;
        for (int i = 0; i < 3 * FRAME && !found; i++) begin
            step();
            n++;
            nft += int'(frame_tick);
            if (game_tick) found = 1'b1;
        end
        check("post_rst_game_seen", 64'(found), 64'd1);
        check("post_rst_game_edges", 64'(n), 64'(2 * FRAME));
        check("post_rst_frame_ticks", 64'(nft), 64'd2);

        @(negedge clk);
        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing from the 100 MHz board clock: the pixel-enable divider, horizontal/vertical counters, active-low sync pulses, the `bright` display-area flag, and frame/game-rate enable pulses. Its `hCount`, `vCount` and `bright` outputs drive the pixel-colour logic (game/level renderer). `hSync` and `vSync` go to the VGA connector. `game_tick` paces object movement without a derived clock.

## Interface
Parameters:
- CLK_DIV, 4, clk cycles per pixel (100 MHz -> 25 MHz)
- H_TOTAL, 800, pixels per line
- H_SYNC, 96, hSync low width in pixels
- H_VIS_START, 144, first visible hCount
- H_VIS_END, 784, first non-visible hCount after the visible region
- V_TOTAL, 525, lines per frame
- V_SYNC, 2, vSync low width in lines
- V_VIS_START, 35, first visible vCount
- V_VIS_END, 515, first non-visible vCount after the visible region
- FRAMES_PER_TICK, 2, frames per `game_tick` pulse (>=1)

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  reset, asynchronous, active-high
- hCount  out  10  horizontal pixel counter, 0..H_TOTAL-1
- vCount  out  10  vertical line counter, 0..V_TOTAL-1
- bright  out  1  high when (hCount, vCount) is inside the visible region
- hSync  out  1  active-low horizontal sync
- vSync  out  1  active-low vertical sync
- pix_tick  out  1  one clk wide; counters advance on the edge that ends this cycle
- frame_tick  out  1  one clk pulse per frame
- game_tick  out  1  one clk pulse every FRAMES_PER_TICK frames

## Operation
- The divider `div` counts 0..CLK_DIV-1 and wraps.
  - `pix_tick` = (div == CLK_DIV-1), decoded from the register.
- On each clk edge with `pix_tick` high:
  - If hCount == H_TOTAL-1: hCount <= 0.
    - If vCount == V_TOTAL-1: vCount <= 0 and the frame wraps.
    - Otherwise: vCount <= vCount+1.
  - Otherwise: hCount <= hCount+1.
- Counters hold on all other edges.
- `bright`, `hSync` and `vSync` are registered and updated on the same edge as the counters. They always describe the currently presented hCount/vCount (zero relative latency).
  - hSync = 0 iff hCount < H_SYNC.
  - vSync = 0 iff vCount < V_SYNC.
  - bright = 1 iff H_VIS_START <= hCount < H_VIS_END and V_VIS_START <= vCount < V_VIS_END.
- `frame_tick` is registered. It is high for exactly the one clk cycle following the edge on which counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0).
- Frame counter `fcnt` counts 0..FRAMES_PER_TICK-1.
  - It increments on each frame wrap and wraps itself to 0.
  - `game_tick` is high for the same cycle as `frame_tick` when the wrap returns fcnt to 0.
  - With FRAMES_PER_TICK=1, game_tick == frame_tick.
- Counter arithmetic is 10-bit unsigned. Counters never take values >= H_TOTAL / V_TOTAL.

## Timing
- Reset values (asynchronous, immediate on rst):
  - div=0, hCount=0, vCount=0, fcnt=0
  - bright=0, hSync=0, vSync=0
  - frame_tick=0, game_tick=0
  - pix_tick=0
- After rst deasserts:
  - Edges 1..CLK_DIV-1 advance div to CLK_DIV-1, which raises pix_tick.
  - Edge CLK_DIV moves hCount to 1.
  - hCount then advances once every CLK_DIV clks.
- Line period: H_TOTAL*CLK_DIV = 3200 clks.
- Frame period: H_TOTAL*V_TOTAL*CLK_DIV = 1,680,000 clks.
- hSync low for H_SYNC*CLK_DIV = 384 clks per line.
- vSync low for V_SYNC lines = 6400 clks per frame. Its edges coincide with hCount=0.
- Simultaneous line and frame wrap are handled in one edge: hCount, vCount and fcnt all update together.
- rst asserted mid-frame abandons the frame. No frame_tick is issued for the partial frame. Timing restarts from (0,0) with fcnt=0.

## Test plan
- Reset: hold rst 5 clks mid-line, then release.
  - -> All outputs are 0 during rst.
  - -> pix_tick first high 3 clks after release.
  - -> hCount=1 after clk 4.
- Horizontal wrap: run to hCount=799, vCount=10.
  - -> Next pix_tick edge gives hCount=0, vCount=11.
  - -> hSync=0 for exactly 384 consecutive clks from that edge.
- Visible region: scan one full frame.
  - -> bright=1 exactly for hCount 144..783 and vCount 35..514.
  - -> 640*480*4 = 1,228,800 bright clks per frame.
- Frame wrap: run to (799,524).
  - -> Next pix_tick edge gives (0,0).
  - -> frame_tick high for one clk.
  - -> vSync=0 for the following 6400 clks.
  - -> frame_tick period measures 1,680,000 clks.
- game_tick: FRAMES_PER_TICK=2, run 5 frames.
  - -> game_tick fires on frame wraps 2 and 4 only.
  - -> Each game_tick is aligned with a frame_tick.
- Async reset mid-frame: assert rst at vCount=300, with fcnt=1.
  - -> Outputs clear without waiting for a clk edge.
  - -> After release, the first game_tick comes after 2 full frames, not 1.
